// File: rtl/hwpe_ctrl_uloop_addrgen_if.sv
// Engine-side and streamer-side handshake bundle of the micro-loop address generator.
// The master modport is the address generator; the slave modport is its environment.
interface hwpe_ctrl_uloop_addrgen_if #(
   parameter int unsigned NB_REG     = 4,
   parameter int unsigned REG_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                                  uloop_clear_o;
   logic                                  uloop_enable_o;
   logic                                  uloop_valid_i;
   logic                                  uloop_done_i;
   logic [NB_REG-1:0][REG_WIDTH-1:0]      uloop_offs_i;
   logic                                  addr_valid_o;
   logic                                  addr_ready_i;
   logic [NB_REG-1:0][ADDR_WIDTH-1:0]     addr_o;

   modport master (
      output uloop_clear_o, uloop_enable_o, addr_valid_o, addr_o,
      input  uloop_valid_i, uloop_done_i, uloop_offs_i, addr_ready_i
   );

   modport slave (
      input  uloop_clear_o, uloop_enable_o, addr_valid_o, addr_o,
      output uloop_valid_i, uloop_done_i, uloop_offs_i, addr_ready_i
   );
endinterface

// File: rtl/hwpe_ctrl_uloop_addrgen.sv
// Pulls offset sets from the micro-loop engine, adds them to per-stream bases and
// queues the resulting address sets for the streamers; pulses done when fully drained.
module hwpe_ctrl_uloop_addrgen #(
   parameter int unsigned NB_REG     = 4,
   parameter int unsigned REG_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              clear_i,
   input  logic                              start_i,
   input  logic [NB_REG-1:0][ADDR_WIDTH-1:0] base_addr_i,
   hwpe_ctrl_uloop_addrgen_if.master         bus,
   output logic                              busy_o,
   output logic                              done_o,
   output logic [CNT_WIDTH-1:0]              cnt_o
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

   typedef logic [NB_REG-1:0][ADDR_WIDTH-1:0] aset_t;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

   state_e               state_q, state_d;
   aset_t                fifo_q [FIFO_DEPTH];
   aset_t                push_data, sum_c;
   logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [OCC_W-1:0]     occ_q, occ_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 enable_q, enable_d;
   logic                 done_q, done_d;
   logic                 push, pop, uloop_clear_c;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      done_d        = 1'b0;
      push          = 1'b0;
      pop           = (occ_q != '0) && bus.addr_ready_i;
      uloop_clear_c = 1'b0;
      for (int i = 0; i < int'(NB_REG); i++) begin
         sum_c[i] = base_addr_i[i] + ADDR_WIDTH'(bus.uloop_offs_i[i]);
      end
      push_data = base_addr_i;

      if (pop) cnt_d = cnt_q + CNT_WIDTH'(1);

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d       = REQ;
               push          = 1'b1;
               cnt_d         = '0;
               uloop_clear_c = 1'b1;
            end
         end
         // enable_q marks the cycle the request is actually issued
         REQ: begin
            if (enable_q) state_d = WAIT;
         end
         WAIT: begin
            if (bus.uloop_valid_i) begin
               if (bus.uloop_done_i) begin
                  state_d = DRAIN;
               end else begin
                  state_d   = REQ;
                  push      = 1'b1;
                  push_data = sum_c;
               end
            end
         end
         DRAIN: begin
            if (occ_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (clear_i) begin
         state_d       = IDLE;
         push          = 1'b0;
         pop           = 1'b0;
         cnt_d         = '0;
         done_d        = 1'b0;
         uloop_clear_c = 1'b0;
      end

      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
      wr_d  = push ? ((wr_q == LAST_C) ? '0 : wr_q + PTR_W'(1)) : wr_q;
      rd_d  = pop  ? ((rd_q == LAST_C) ? '0 : rd_q + PTR_W'(1)) : rd_q;
      if (clear_i) begin
         occ_d = '0;
         wr_d  = '0;
         rd_d  = '0;
      end

      // a request is only issued once a FIFO slot is guaranteed for its response
      enable_d = (state_d == REQ) && (occ_d < DEPTH_C);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         wr_q     <= '0;
         rd_q     <= '0;
         occ_q    <= '0;
         cnt_q    <= '0;
         enable_q <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
         enable_q <= enable_d;
         done_q   <= done_d;
         if (push) fifo_q[wr_q] <= push_data;
      end
   end

   assign bus.uloop_clear_o  = uloop_clear_c;
   assign bus.uloop_enable_o = enable_q;
   assign bus.addr_valid_o   = (occ_q != '0);
   assign bus.addr_o         = fifo_q[rd_q];
   assign busy_o             = (state_q != IDLE);
   assign done_o             = done_q;
   assign cnt_o              = cnt_q;

endmodule

// File: doc/hwpe_ctrl_uloop_addrgen.md
# hwpe_ctrl_uloop_addrgen

Downstream companion of the shadowed micro-loop engine in the HWPE control path. It pulls offset sets from the engine with a one-outstanding enable/valid protocol. It adds each offset set to per-stream base addresses and delivers the resulting address sets to the streamers through a valid/ready FIFO. It signals job completion once the engine reports done and every buffered address set has been consumed.

## Interface
Parameters:
- NB_REG, 4: number of streams; equals the engine's writable register count.
- REG_WIDTH, 32: width of each engine offset.
- ADDR_WIDTH, 32: width of each base and output address.
- CNT_WIDTH, 16: width of the delivered-set counter.
- FIFO_DEPTH, 2: output address-set FIFO depth; must be ≥1.

Ports:
- clk_i  in  1  clock; everything is rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous soft clear.
- start_i  in  1  job start; honoured only in IDLE.
- base_addr_i  in  NB_REG×ADDR_WIDTH  per-stream base; sampled every cycle a set is pushed.
- uloop_clear_o  out  1  clear pulse to the engine.
- uloop_enable_o  out  1  request pulse to the engine.
- uloop_valid_i  in  1  engine response strobe.
- uloop_done_i  in  1  engine done flag; qualified by uloop_valid_i.
- uloop_offs_i  in  NB_REG×REG_WIDTH  engine offsets; qualified by uloop_valid_i.
- addr_valid_o  out  1  FIFO head valid.
- addr_ready_i  in  1  streamer accept.
- addr_o  out  NB_REG×ADDR_WIDTH  FIFO head address set.
- busy_o  out  1  high whenever state ≠ IDLE.
- done_o  out  1  single-cycle job-complete pulse.
- cnt_o  out  CNT_WIDTH  address sets popped in the current job.

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE → REQ on start_i, unless clear_i is also high:
  - pulse uloop_clear_o for that cycle;
  - push base_addr_i, zero offsets, as set 0; the FIFO is always empty in IDLE;
  - reset cnt_o to 0.
- REQ:
  - assert uloop_enable_o for exactly one cycle when the FIFO holds fewer than FIFO_DEPTH entries;
  - go to WAIT in that same cycle.
  - If the FIFO is full, stay in REQ with uloop_enable_o low.
- WAIT: never more than one request is outstanding. On uloop_valid_i:
  - if uloop_done_i = 0: push base_addr_i[i] + offs[i] for each i, go to REQ;
  - if uloop_done_i = 1: push nothing, go to DRAIN.
- DRAIN: when the FIFO is empty, go to IDLE and register a done_o pulse.
- Address arithmetic:
  - each offset is zero-extended or truncated to ADDR_WIDTH;
  - the sum is modulo 2^ADDR_WIDTH; there is no overflow flag.
- Pop happens when addr_valid_o & addr_ready_i. Push and pop in the same cycle are legal at any occupancy. Push never overflows because a slot is reserved before each enable.
- cnt_o increments on each pop and wraps modulo 2^CNT_WIDTH.
- uloop_valid_i outside WAIT is ignored.
- start_i outside IDLE is ignored.
- clear_i, from any state:
  - next cycle: state IDLE, FIFO empty, addr_valid_o = 0, cnt_o = 0;
  - no done_o pulse;
  - clear_i has priority over start_i, pushes, and pops.
- rst_i mid-job behaves as clear_i, but acts immediately and asynchronously.

## Timing
- Reset values: uloop_clear_o = 0, uloop_enable_o = 0, addr_valid_o = 0, addr_o = 0, busy_o = 0, done_o = 0, cnt_o = 0, state IDLE.
- FIFO outputs are registered. A set pushed in cycle t is visible at addr_o in cycle t+1 at the earliest.
- For start_i in cycle 0:
  - cycle 1: busy_o = 1, addr_valid_o = 1 with the base set, uloop_enable_o = 1.
- Engine response latency is ≥1 cycle after uloop_enable_o.
- Next enable comes no earlier than 1 cycle after the response.
- Steady-state throughput is one set per two cycles with a 1-cycle engine.
- done_o and busy_o = 0 appear in the cycle after DRAIN observes an empty FIFO.
- done_o is high exactly one cycle.

## Test plan
- Nominal job:
  - stimulus: NB_REG = 2, base {0x1000, 0x2000}; engine model returns offsets {4,4}, then {8,8}, then done; addr_ready_i = 1;
  - required: sets 0x1000/0x2000, 0x1004/0x2004, 0x1008/0x2008; one done_o pulse; cnt_o = 3; uloop_clear_o pulsed once at start.
- Backpressure:
  - stimulus: addr_ready_i = 0 for 12 cycles with FIFO_DEPTH = 2;
  - required: FIFO holds at most 2 sets; no uloop_enable_o while full; all sets delivered in order after release.
- Wrap-around:
  - stimulus: base 0xFFFF_FFF0, offset 0x20;
  - required: address 0x0000_0010.
- Immediate done:
  - stimulus: first engine response has done = 1;
  - required: only the base set is delivered, then done_o; cnt_o = 1.
- Clear mid-job:
  - stimulus: clear_i in WAIT with 1 set buffered; a late uloop_valid_i arrives next cycle;
  - required: addr_valid_o = 0 and busy_o = 0 next cycle; no push; no done_o.
- Start conflicts:
  - stimulus: start_i while busy, then start_i together with clear_i;
  - required: both are ignored; state remains IDLE after the clear.
